// File: rtl/mac_r_frame_parser.sv
// MII/GMII receive frame parser: preamble/SFD detection, CRC-32 check, FCS/tail-tag stripping.
// Optional tail-tag handling is enabled with the MAC_R_TAILTAG_EN macro.
module mac_r_frame_parser #(
  parameter int          MAX_LEN   = 1522,
  parameter int          MIN_LEN   = 64,
  parameter int          PORT_NUM  = 4,
  parameter logic [15:0] TTE_TYPE0 = 16'h88F7,
  parameter logic [15:0] TTE_TYPE1 = 16'h0892,
  localparam int         PORT_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_sys,
  input  logic [1:0]        speed,
  input  logic              rx_ce,
  input  logic              rx_dv,
  input  logic [7:0]        rx_d,
  input  logic [31:0]       counter_ns,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic              stat_valid,
  output logic [10:0]       stat_len,
  output logic              stat_crc_ok,
  output logic              stat_len_err,
  output logic              stat_tte,
  output logic              stat_tag_err,
  output logic [PORT_W-1:0] stat_port,
  output logic [31:0]       stat_ts
);

`ifdef MAC_R_TAILTAG_EN
  localparam int D = 5;
`else
  localparam int D = 4;
`endif
  localparam int          DEPTH       = D + 1;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    WAIT_IFG = 3'd0,
    IDLE     = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    DROP     = 3'd4
  } state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

`ifdef MAC_R_TAILTAG_EN
  function automatic logic tag_onehot(input logic [7:0] t);
    logic ok;
    int   n;
    ok = 1'b1;
    n  = 0;
    for (int i = 0; i < 8; i++) begin
      if (t[i]) begin
        n++;
        if (i >= PORT_NUM) ok = 1'b0;
      end
    end
    return ok && (n == 1);
  endfunction

  function automatic logic [PORT_W-1:0] tag_index(input logic [7:0] t);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PORT_NUM && i < 8; i++) begin
      if (t[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction
`endif

  state_t            state_r, state_nxt_s;
  logic              mii_r, nib_ph_r, tte_r, ovf_r;
  logic [3:0]        nib_lo_r, rx_cnt_r;
  logic [7:0]        buf_r [0:DEPTH-1];
  logic [7:0]        type_hi_r;
  logic [2:0]        cnt_r;
  logic [31:0]       crc_r;
  logic [10:0]       out_cnt_r;
  logic              gmii_s, byte_stb_s, end_s, full_s, tag_ok_s, len_bad_s;
  logic              start_s, push_s, emit_s, eof_s, fin_s, ovf_s;
  logic [7:0]        byte_s;
  logic [10:0]       len_s;
  logic [31:0]       len_ext_s;
  logic [PORT_W-1:0] tag_idx_s;

  // The line mode follows the live speed until SFD, then the value latched there.
  assign gmii_s     = (state_r == DATA || state_r == DROP) ? ~mii_r : (speed == 2'b10);
  assign byte_stb_s = rx_ce & rx_dv & (gmii_s | nib_ph_r);
  assign byte_s     = gmii_s ? rx_d : {rx_d[3:0], nib_lo_r};
  assign end_s      = rx_ce & ~rx_dv;
  assign full_s     = (cnt_r == 3'(DEPTH));
  assign len_s      = out_cnt_r + {10'd0, emit_s};
  assign len_ext_s  = {21'd0, len_s} + 32'd4;
  assign len_bad_s  = ovf_r | (len_ext_s < 32'(MIN_LEN)) | (len_ext_s > 32'(MAX_LEN));
`ifdef MAC_R_TAILTAG_EN
  assign tag_ok_s   = tag_onehot(buf_r[1]);
  assign tag_idx_s  = tag_ok_s ? tag_index(buf_r[1]) : '0;
`else
  assign tag_ok_s   = 1'b1;
  assign tag_idx_s  = '0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_sys) state_r <= WAIT_IFG;
    else         state_r <= state_nxt_s;
  end

  // Next-state and per-byte control decode
  always_comb begin
    state_nxt_s = state_r;
    start_s = 1'b0; push_s = 1'b0; emit_s = 1'b0;
    eof_s   = 1'b0; fin_s  = 1'b0; ovf_s  = 1'b0;
    case (state_r)
      WAIT_IFG: if (end_s) state_nxt_s = IDLE; else state_nxt_s = WAIT_IFG;
      IDLE: if (byte_stb_s) state_nxt_s = (byte_s == 8'h55) ? PREAMBLE : DROP;
            else            state_nxt_s = IDLE;
      PREAMBLE: begin
        if (end_s)                                   state_nxt_s = IDLE;
        else if (byte_stb_s && byte_s == 8'h55)      state_nxt_s = PREAMBLE;
        else if (byte_stb_s && byte_s == 8'hD5) begin
          state_nxt_s = DATA;
          start_s     = 1'b1;
        end
        else if (byte_stb_s)                         state_nxt_s = DROP;
        else                                         state_nxt_s = PREAMBLE;
      end
      DATA: begin
        if (end_s) begin
          fin_s       = 1'b1;
          emit_s      = full_s;
          eof_s       = full_s;
          state_nxt_s = IDLE;
        end else if (byte_stb_s) begin
          push_s = 1'b1;
          emit_s = full_s;
          // Truncate an overlong frame at its last legal byte
          if (full_s && out_cnt_r == 11'(MAX_LEN - 5)) begin
            eof_s       = 1'b1;
            ovf_s       = 1'b1;
            state_nxt_s = DROP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      DROP: begin
        if (end_s) begin
          fin_s       = ovf_r;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: state_nxt_s = WAIT_IFG;
    endcase
  end

  // Nibble assembly, delay buffer, CRC and registered outputs
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      mii_r <= 1'b0; nib_ph_r <= 1'b0; nib_lo_r <= 4'h0; tte_r <= 1'b0; ovf_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_r[i] <= 8'h00;
      cnt_r <= 3'd0; crc_r <= 32'h00000000; rx_cnt_r <= 4'd0; out_cnt_r <= 11'd0;
      type_hi_r <= 8'h00;
      out_data <= 8'h00; out_valid <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0;
      stat_valid <= 1'b0; stat_len <= 11'd0; stat_crc_ok <= 1'b0; stat_len_err <= 1'b0;
      stat_tte <= 1'b0; stat_tag_err <= 1'b0; stat_port <= '0; stat_ts <= 32'h00000000;
    end else begin
      out_valid  <= emit_s;
      out_data   <= emit_s ? buf_r[0] : 8'h00;
      out_sof    <= emit_s && (out_cnt_r == 11'd0);
      out_eof    <= eof_s;
      stat_valid <= fin_s;

      if (rx_ce && rx_dv && !gmii_s) begin
        if (!nib_ph_r) nib_lo_r <= rx_d[3:0];
        nib_ph_r <= ~nib_ph_r;
      end else if (end_s) begin
        nib_ph_r <= 1'b0;
      end

      if (start_s) begin
        mii_r     <= (speed != 2'b10);
        stat_ts   <= counter_ns;
        crc_r     <= 32'hFFFFFFFF;
        cnt_r     <= 3'd0;
        rx_cnt_r  <= 4'd0;
        out_cnt_r <= 11'd0;
        tte_r     <= 1'b0;
        ovf_r     <= 1'b0;
      end

      if (push_s) begin
        crc_r <= crc32_byte(crc_r, byte_s);
        for (int i = 0; i < DEPTH - 1; i++) buf_r[i] <= buf_r[i+1];
        buf_r[DEPTH-1] <= byte_s;
        if (!full_s) cnt_r <= cnt_r + 3'd1;
        if (rx_cnt_r != 4'hF) rx_cnt_r <= rx_cnt_r + 4'd1;
        if (rx_cnt_r == 4'd12) type_hi_r <= byte_s;
        if (rx_cnt_r == 4'd13) tte_r <= ({type_hi_r, byte_s} == TTE_TYPE0) ||
                                        ({type_hi_r, byte_s} == TTE_TYPE1);
      end

      if (emit_s) out_cnt_r <= out_cnt_r + 11'd1;
      if (ovf_s)  ovf_r <= 1'b1;

      if (fin_s) begin
        stat_len     <= len_s;
        stat_crc_ok  <= (crc_r == CRC_RESIDUE) && !nib_ph_r && !ovf_r;
        stat_len_err <= len_bad_s;
        stat_tte     <= tte_r;
        stat_tag_err <= eof_s && !ovf_r && !tag_ok_s;
        stat_port    <= (eof_s && !ovf_r) ? tag_idx_s : '0;
        ovf_r        <= 1'b0;
        cnt_r        <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_mac_r_frame_parser.sv
// Directed self-checking bench for mac_r_frame_parser (GMII, MII, short/long frames, reset abort).
// Tail-tag expectations follow the MAC_R_TAILTAG_EN macro.
module tb_mac_r_frame_parser;

  logic        clk = 1'b0;
  logic        rst_sys = 1'b1;
  logic [1:0]  speed = 2'b10;
  logic        rx_ce = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_d = 8'h00;
  logic [31:0] counter_ns = 32'h10000000;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, stat_valid;
  logic [10:0] stat_len;
  logic        stat_crc_ok, stat_len_err, stat_tte, stat_tag_err;
  logic [1:0]  stat_port;
  logic [31:0] stat_ts;

`ifdef MAC_R_TAILTAG_EN
  localparam logic [1:0] EXP_PORT = 2'd2;
`else
  localparam logic [1:0] EXP_PORT = 2'd0;
`endif

  mac_r_frame_parser dut (
    .clk(clk), .rst_sys(rst_sys), .speed(speed), .rx_ce(rx_ce), .rx_dv(rx_dv), .rx_d(rx_d),
    .counter_ns(counter_ns), .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .stat_valid(stat_valid), .stat_len(stat_len), .stat_crc_ok(stat_crc_ok),
    .stat_len_err(stat_len_err), .stat_tte(stat_tte), .stat_tag_err(stat_tag_err),
    .stat_port(stat_port), .stat_ts(stat_ts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) counter_ns <= counter_ns + 32'd1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frm [$];
  int          exp_n;
  logic [31:0] exp_ts;

  // Monitor: collects emitted bytes and the latest status, sampled 1 ns after each edge
  logic [7:0]  q_out [$];
  int          sof_n = 0, eof_n = 0, st_n = 0, cyc = 0;
  int          sof_idx = -1, eof_idx = -1, eof_cyc = -1, st_cyc = -1;
  logic [10:0] m_len;
  logic        m_crc, m_lerr, m_tte, m_terr;
  logic [1:0]  m_port;
  logic [31:0] m_ts;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) begin
        q_out.push_back(out_data);
        if (out_sof) begin sof_n++; sof_idx = q_out.size() - 1; end
        if (out_eof) begin eof_n++; eof_idx = q_out.size() - 1; eof_cyc = cyc; end
      end
      if (stat_valid) begin
        st_n++; st_cyc = cyc;
        m_len = stat_len; m_crc = stat_crc_ok; m_lerr = stat_len_err; m_tte = stat_tte;
        m_terr = stat_tag_err; m_port = stat_port; m_ts = stat_ts;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic build_frame(input int n, input logic [15:0] typ, input logic bad, input logic [7:0] tag);
    logic [31:0] c;
    logic        fb;
    logic [7:0]  b;
    frm.delete();
    exp_n = n;
    for (int i = 0; i < n; i++) begin
      if (i < 6)        b = 8'hF0 + 8'(i);
      else if (i < 12)  b = 8'hE0 + 8'(i - 6);
      else if (i == 12) b = typ[15:8];
      else if (i == 13) b = typ[7:0];
      else              b = 8'(i * 7 + 3);
      frm.push_back(b);
    end
`ifdef MAC_R_TAILTAG_EN
    frm.push_back(tag);
`else
    if (tag == 8'h00) b = 8'h00;
`endif
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm.size(); i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ frm[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = bad ? c : ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic mii);
    if (mii) begin
      @(negedge clk); rx_dv = 1'b1; rx_d = {4'h0, b[3:0]};
      @(negedge clk); rx_d = {4'h0, b[7:4]};
    end else begin
      @(negedge clk); rx_dv = 1'b1; rx_d = b;
    end
  endtask

  task automatic idle_n(input int n);
    repeat (n) begin @(negedge clk); rx_dv = 1'b0; rx_d = 8'h00; end
  endtask

  // Preamble + SFD + frm contents, ending with exactly one rx_dv=0 sample
  task automatic send(input logic mii, input logic odd, input int rst_at);
    speed = mii ? 2'b01 : 2'b10;
    for (int i = 0; i < 7; i++) drive_byte(8'h55, mii);
    drive_byte(8'hD5, mii);
    exp_ts = counter_ns;
    for (int i = 0; i < frm.size(); i++) begin
      drive_byte(frm[i], mii);
      rst_sys = (i == rst_at);
    end
    if (odd) begin @(negedge clk); rst_sys = 1'b0; rx_d = 8'h0A; end
    @(negedge clk); rst_sys = 1'b0; rx_dv = 1'b0; rx_d = 8'h00;
  endtask

  function automatic int data_mism(input int b0);
    int m;
    m = 0;
    if (q_out.size() < b0 + exp_n) return 1;
    for (int i = 0; i < exp_n; i++) if (q_out[b0 + i] !== frm[i]) m++;
    return m;
  endfunction

  task automatic test_reset;
    rst_sys = 1'b1;
    idle_n(3);
    checks++; if ({out_valid, out_sof, out_eof, out_data} !== 11'd0) begin errors++; $display("FAIL rst_out got %0h exp 0", {out_valid, out_sof, out_eof, out_data}); end
    checks++; if ({stat_valid, stat_len, stat_crc_ok, stat_len_err, stat_tte, stat_ts} !== 47'd0) begin errors++; $display("FAIL rst_stat got %0h exp 0", {stat_valid, stat_len, stat_crc_ok, stat_len_err, stat_tte, stat_ts}); end
    rst_sys = 1'b0;
    idle_n(2);
  endtask

  task automatic test_gmii_good;
    int b0, s0, e0, f0;
    build_frame(100, 16'h88F7, 1'b0, 8'h04);
    b0 = q_out.size(); s0 = st_n; e0 = eof_n; f0 = sof_n;
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 100) begin errors++; $display("FAIL g_count got %0d exp 100", q_out.size() - b0); end
    checks++; if (data_mism(b0) !== 0) begin errors++; $display("FAIL g_data got %0d bad bytes exp 0", data_mism(b0)); end
    checks++; if (sof_n - f0 !== 1 || sof_idx !== b0) begin errors++; $display("FAIL g_sof got idx %0d exp %0d", sof_idx, b0); end
    checks++; if (eof_n - e0 !== 1 || eof_idx !== b0 + 99) begin errors++; $display("FAIL g_eof got idx %0d exp %0d", eof_idx, b0 + 99); end
    checks++; if (st_n - s0 !== 1) begin errors++; $display("FAIL g_stat_n got %0d exp 1", st_n - s0); end
    checks++; if (st_cyc !== eof_cyc) begin errors++; $display("FAIL g_stat_cyc got %0d exp %0d", st_cyc, eof_cyc); end
    checks++; if (m_len !== 11'd100) begin errors++; $display("FAIL g_len got %0d exp 100", m_len); end
    checks++; if (m_crc !== 1'b1) begin errors++; $display("FAIL g_crc got %0d exp 1", m_crc); end
    checks++; if (m_tte !== 1'b1) begin errors++; $display("FAIL g_tte got %0d exp 1", m_tte); end
    checks++; if (m_lerr !== 1'b0) begin errors++; $display("FAIL g_lerr got %0d exp 0", m_lerr); end
    checks++; if (m_port !== EXP_PORT || m_terr !== 1'b0) begin errors++; $display("FAIL g_port got %0d/%0d exp %0d/0", m_port, m_terr, EXP_PORT); end
    checks++; if (m_ts !== exp_ts) begin errors++; $display("FAIL g_ts got %0h exp %0h", m_ts, exp_ts); end
  endtask

  task automatic test_bad_fcs;
    int b0, s0;
    build_frame(100, 16'h88F7, 1'b1, 8'h04);
    b0 = q_out.size(); s0 = st_n;
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 100) begin errors++; $display("FAIL bf_count got %0d exp 100", q_out.size() - b0); end
    checks++; if (st_n - s0 !== 1 || m_crc !== 1'b0) begin errors++; $display("FAIL bf_crc got n=%0d crc=%0d exp n=1 crc=0", st_n - s0, m_crc); end
  endtask

  task automatic test_short_len;
    build_frame(59, 16'h0800, 1'b0, 8'h01);
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (m_len !== 11'd59 || m_lerr !== 1'b1) begin errors++; $display("FAIL sl_len got %0d/%0d exp 59/1", m_len, m_lerr); end
    checks++; if (m_tte !== 1'b0 || m_crc !== 1'b1) begin errors++; $display("FAIL sl_flags got tte=%0d crc=%0d exp 0/1", m_tte, m_crc); end
  endtask

  task automatic test_overlong;
    int b0, s0, e0;
    build_frame(1519, 16'h0892, 1'b0, 8'h04);
    b0 = q_out.size(); s0 = st_n; e0 = eof_n;
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 1518) begin errors++; $display("FAIL ol_count got %0d exp 1518", q_out.size() - b0); end
    checks++; if (eof_n - e0 !== 1 || eof_idx !== b0 + 1517) begin errors++; $display("FAIL ol_eof got idx %0d exp %0d", eof_idx, b0 + 1517); end
    checks++; if (st_n - s0 !== 1 || st_cyc <= eof_cyc) begin errors++; $display("FAIL ol_stat got n=%0d cyc=%0d exp n=1 after %0d", st_n - s0, st_cyc, eof_cyc); end
    checks++; if (m_len !== 11'd1518 || m_lerr !== 1'b1 || m_tte !== 1'b1) begin errors++; $display("FAIL ol_status got len=%0d lerr=%0d tte=%0d exp 1518/1/1", m_len, m_lerr, m_tte); end
  endtask

  task automatic test_mii;
    int b0, s0;
    build_frame(68, 16'h88F7, 1'b0, 8'h04);
    for (int m = 0; m < 2; m++) begin
      b0 = q_out.size(); s0 = st_n;
      send(m[0], 1'b0, -1);
      idle_n(3);
      checks++; if (q_out.size() - b0 !== 68 || data_mism(b0) !== 0) begin errors++; $display("FAIL mii%0d_data got %0d bytes exp 68", m, q_out.size() - b0); end
      checks++; if (st_n - s0 !== 1 || m_len !== 11'd68 || m_crc !== 1'b1 || m_lerr !== 1'b0 || m_tte !== 1'b1)
        begin errors++; $display("FAIL mii%0d_stat got n=%0d len=%0d crc=%0d lerr=%0d tte=%0d exp 1/68/1/0/1", m, st_n - s0, m_len, m_crc, m_lerr, m_tte); end
      checks++; if (m_ts !== exp_ts) begin errors++; $display("FAIL mii%0d_ts got %0h exp %0h", m, m_ts, exp_ts); end
    end
  endtask

  task automatic test_mii_odd;
    int b0;
    build_frame(68, 16'h88F7, 1'b0, 8'h04);
    b0 = q_out.size();
    send(1'b1, 1'b1, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 68 || m_len !== 11'd68 || m_crc !== 1'b0)
      begin errors++; $display("FAIL odd_nib got bytes=%0d len=%0d crc=%0d exp 68/68/0", q_out.size() - b0, m_len, m_crc); end
  endtask

  task automatic test_short_frame;
    int b0, s0;
    frm.delete(); frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
    b0 = q_out.size(); s0 = st_n;
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 0) begin errors++; $display("FAIL sf_out got %0d bytes exp 0", q_out.size() - b0); end
    checks++; if (st_n - s0 !== 1 || m_lerr !== 1'b1 || m_len !== 11'd0) begin errors++; $display("FAIL sf_stat got n=%0d lerr=%0d len=%0d exp 1/1/0", st_n - s0, m_lerr, m_len); end
  endtask

  task automatic test_back_to_back;
    int b0, s0, e0, f0;
    build_frame(64, 16'h0800, 1'b0, 8'h08);
    b0 = q_out.size(); s0 = st_n; e0 = eof_n; f0 = sof_n;
    send(1'b0, 1'b0, -1);
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 128 || sof_n - f0 !== 2 || eof_n - e0 !== 2)
      begin errors++; $display("FAIL b2b_out got bytes=%0d sof=%0d eof=%0d exp 128/2/2", q_out.size() - b0, sof_n - f0, eof_n - e0); end
    checks++; if (st_n - s0 !== 2 || m_crc !== 1'b1 || m_len !== 11'd64) begin errors++; $display("FAIL b2b_stat got n=%0d crc=%0d len=%0d exp 2/1/64", st_n - s0, m_crc, m_len); end
  endtask

  task automatic test_reset_midframe;
    int b0, s0, e0;
    build_frame(100, 16'h88F7, 1'b0, 8'h04);
    s0 = st_n; e0 = eof_n;
    send(1'b0, 1'b0, 40);
    idle_n(3);
    checks++; if (st_n - s0 !== 0 || eof_n - e0 !== 0) begin errors++; $display("FAIL rm_abort got stat=%0d eof=%0d exp 0/0", st_n - s0, eof_n - e0); end
    b0 = q_out.size(); s0 = st_n;
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (q_out.size() - b0 !== 100 || data_mism(b0) !== 0 || eof_idx !== b0 + 99)
      begin errors++; $display("FAIL rm_next_data got bytes=%0d eof=%0d exp 100/%0d", q_out.size() - b0, eof_idx, b0 + 99); end
    checks++; if (st_n - s0 !== 1 || m_len !== 11'd100 || m_crc !== 1'b1 || m_tte !== 1'b1 || m_lerr !== 1'b0)
      begin errors++; $display("FAIL rm_next_stat got n=%0d len=%0d crc=%0d tte=%0d lerr=%0d exp 1/100/1/1/0", st_n - s0, m_len, m_crc, m_tte, m_lerr); end
  endtask

`ifdef MAC_R_TAILTAG_EN
  task automatic test_bad_tag;
    build_frame(100, 16'h88F7, 1'b0, 8'h06);
    send(1'b0, 1'b0, -1);
    idle_n(3);
    checks++; if (m_terr !== 1'b1 || m_port !== 2'd0 || m_crc !== 1'b1) begin errors++; $display("FAIL tag_err got err=%0d port=%0d crc=%0d exp 1/0/1", m_terr, m_port, m_crc); end
  endtask
`endif

  initial begin
    test_reset();
    test_gmii_good();
    test_bad_fcs();
    test_short_len();
    test_overlong();
    test_mii();
    test_mii_odd();
    test_short_frame();
    test_back_to_back();
    test_reset_midframe();
`ifdef MAC_R_TAILTAG_EN
    test_bad_tag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
